// File: rtl/fma_norm_pipe.sv
// fma_norm_pipe: two-stage leading-zero normalizer for the FMA sum magnitude, with valid/ready flow control.
// Optional feature: define FMA_NORM_SUBN_CLAMP_EN to limit the shift so subnormal results keep Me >= 1.
typedef struct packed {
  int NE;
  int NF;
  int BIAS;
} cvw_t;

module fma_norm_pipe #(
  parameter cvw_t P = '{NE: 11, NF: 52, BIAS: 1023}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush,
  input  logic                InValid,
  output logic                InReady,
  input  logic [3*P.NF+3:0]   Sm,
  input  logic [P.NE+1:0]     Pe,
  input  logic                Ss,
  input  logic                ASticky,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [3*P.NF+3:0]   Mm,
  output logic [P.NE+1:0]     Me,
  output logic                Ms,
  output logic                Sticky,
  output logic                SumZero
);

  localparam int SW = 3*P.NF + 4;
  localparam int EW = P.NE + 2;
  localparam int CW = $clog2(SW + 1);

  function automatic logic [CW-1:0] lzc(input logic [SW-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = CW'(SW);
    found = 1'b0;
    for (int i = SW-1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = CW'(SW-1-i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic                 r_s1_vld;
  logic [SW-1:0]        r_s1_sm;
  logic signed [EW-1:0] r_s1_pe;
  logic                 r_s1_ss;
  logic                 r_s1_ast;

  logic                 r_s2_vld;
  logic [SW-1:0]        r_s2_mm;
  logic signed [EW-1:0] r_s2_me;
  logic                 r_s2_ms;
  logic                 r_s2_st;
  logic                 r_s2_zero;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_acc;
  logic [CW-1:0]        w_ncnt;
  logic [CW-1:0]        w_sh;
  logic                 w_zero;
  logic [SW-1:0]        w_mm;
  logic signed [EW-1:0] w_me;

  assign w_s2_adv = ~r_s2_vld | OutReady;
  assign w_s1_adv = ~r_s1_vld | w_s2_adv;
  assign InReady  = ~r_s1_vld | w_s1_adv;
  assign w_acc    = InValid & InReady;

  assign w_ncnt = lzc(r_s1_sm);
  assign w_zero = (r_s1_sm == '0);

`ifdef FMA_NORM_SUBN_CLAMP_EN
  // Limit L = Pe + NF + 1 is the shift that lands the exponent exactly on 1.
  logic signed [EW:0] w_lim;
  logic signed [EW:0] w_ncnt_ext;
  assign w_lim      = $signed({r_s1_pe[EW-1], r_s1_pe}) + $signed((EW+1)'(P.NF + 1));
  assign w_ncnt_ext = $signed({{(EW+1-CW){1'b0}}, w_ncnt});

  always_comb begin
    w_sh = w_ncnt;
    if (w_lim[EW]) begin
      w_sh = '0;
    end else if (w_lim < w_ncnt_ext) begin
      w_sh = w_lim[CW-1:0];
    end
  end
`else
  assign w_sh = w_ncnt;
`endif

  assign w_mm = w_zero ? '0 : (r_s1_sm << w_sh);
  assign w_me = w_zero ? '0
              : r_s1_pe + $signed(EW'(P.NF + 2)) - $signed({{(EW-CW){1'b0}}, w_sh});

  // Stage 1: capture accepted inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1_sm  <= '0;
      r_s1_pe  <= '0;
      r_s1_ss  <= 1'b0;
      r_s1_ast <= 1'b0;
    end else begin
      if (Flush) begin
        r_s1_vld <= 1'b0;
      end else if (w_s1_adv) begin
        r_s1_vld <= w_acc;
      end
      if (w_acc) begin
        r_s1_sm  <= Sm;
        r_s1_pe  <= $signed(Pe);
        r_s1_ss  <= Ss;
        r_s1_ast <= ASticky;
      end
    end
  end

  // Stage 2: capture normalized result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_mm   <= '0;
      r_s2_me   <= '0;
      r_s2_ms   <= 1'b0;
      r_s2_st   <= 1'b0;
      r_s2_zero <= 1'b0;
    end else begin
      if (Flush) begin
        r_s2_vld <= 1'b0;
      end else if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
      end
      if (w_s2_adv && r_s1_vld) begin
        r_s2_mm   <= w_mm;
        r_s2_me   <= w_me;
        r_s2_ms   <= r_s1_ss;
        r_s2_st   <= r_s1_ast;
        r_s2_zero <= w_zero;
      end
    end
  end

  assign OutValid = r_s2_vld;
  assign Mm       = r_s2_mm;
  assign Me       = r_s2_me;
  assign Ms       = r_s2_ms;
  assign Sticky   = r_s2_st;
  assign SumZero  = r_s2_zero;

endmodule
